// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync and blank decode with a programmable
// alignment delay, plus frame and animation pulses for the sprite renderers.

module vga_timing_gen_chk #(
  parameter logic [9:0] H_LAST = 10'd799,
  parameter logic [9:0] V_LAST = 10'd524
) (
  input logic       clk_i,
  input logic       rst_i,
  input logic [9:0] hc_i,
  input logic [9:0] vc_i,
  input logic       line_start_i,
  input logic       frame_start_i,
  input logic       anim_tick_i
);

  a_frame_on_line: assert property (@(posedge clk_i) disable iff (rst_i)
    frame_start_i |-> line_start_i);

  a_anim_on_frame: assert property (@(posedge clk_i) disable iff (rst_i)
    anim_tick_i |-> frame_start_i);

  a_hc_range: assert property (@(posedge clk_i) disable iff (rst_i)
    hc_i <= H_LAST);

  a_vc_range: assert property (@(posedge clk_i) disable iff (rst_i)
    vc_i <= V_LAST);

endmodule

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1,
  parameter int ANIM_DIV   = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       line_start,
  output logic [7:0] frame_count,
  output logic       anim_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int            AW        = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

  logic [9:0]    hc_q, hc_d;
  logic [9:0]    vc_q, vc_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          anim_tick_q, anim_tick_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [AW-1:0] anim_q, anim_d;
  logic          hs_raw, vs_raw, blank_raw;

  // Raster position advance with line and frame wrap
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = 10'd0;
      if (vc_q == V_LAST) begin
        vc_d = 10'd0;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end else begin
      hc_d = hc_q + 10'd1;
    end
  end

  // Line/frame pulses come from the next position so they line up with hc==0
  always_comb begin
    line_start_d  = (hc_d == 10'd0);
    frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
    frame_count_d = frame_count_q;
    anim_d        = anim_q;
    anim_tick_d   = 1'b0;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 8'd1;
      if (anim_q == ANIM_LAST) begin
        anim_d      = '0;
        anim_tick_d = 1'b1;
      end else begin
        anim_d      = anim_q + AW'(1);
        anim_tick_d = 1'b0;
      end
    end else begin
      frame_count_d = frame_count_q;
      anim_d        = anim_q;
    end
  end

  // Counter and pulse state
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      anim_tick_q   <= 1'b0;
      frame_count_q <= 8'd0;
      anim_q        <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      anim_tick_q   <= anim_tick_d;
      frame_count_q <= frame_count_d;
      anim_q        <= anim_d;
    end
  end

  // Undelayed sync/blank decode of the current position
  always_comb begin
    hs_raw    = !((hc_q >= HS_BEGIN) && (hc_q < HS_END));
    vs_raw    = !((vc_q >= VS_BEGIN) && (vc_q < VS_END));
    blank_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  end

  // Delay line keeps hs/vs/blank aligned with the renderer's registered colour
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hs    = hs_raw;
      assign vs    = vs_raw;
      assign blank = blank_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_q;
      logic [SYNC_DELAY-1:0] vs_pipe_q;
      logic [SYNC_DELAY-1:0] blank_pipe_q;

      // Shift the raw decode through SYNC_DELAY stages
      always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
          hs_pipe_q    <= '1;
          vs_pipe_q    <= '1;
          blank_pipe_q <= '0;
        end else begin
          hs_pipe_q[0]    <= hs_raw;
          vs_pipe_q[0]    <= vs_raw;
          blank_pipe_q[0] <= blank_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe_q[i]    <= hs_pipe_q[i-1];
            vs_pipe_q[i]    <= vs_pipe_q[i-1];
            blank_pipe_q[i] <= blank_pipe_q[i-1];
          end
        end
      end

      assign hs    = hs_pipe_q[SYNC_DELAY-1];
      assign vs    = vs_pipe_q[SYNC_DELAY-1];
      assign blank = blank_pipe_q[SYNC_DELAY-1];
    end
  endgenerate

  assign sync        = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign anim_tick   = anim_tick_q;

  vga_timing_gen_chk #(
    .H_LAST(H_LAST),
    .V_LAST(V_LAST)
  ) u_chk (
    .clk_i        (vga_clk),
    .rst_i        (Reset),
    .hc_i         (hc_q),
    .vc_i         (vc_q),
    .line_start_i (line_start_q),
    .frame_start_i(frame_start_q),
    .anim_tick_i  (anim_tick_q)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing plus two reduced rasters (15x8 totals)
// with SYNC_DELAY 0 and 3 for frame-level and wrap behaviour.

module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic Reset   = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  always #5 vga_clk = ~vga_clk;

  logic       d_hs, d_vs, d_blank, d_sync, d_fs, d_ls, d_at;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       a_hs, a_vs, a_blank, a_sync, a_fs, a_ls, a_at;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_blank, b_sync, b_fs, b_ls, b_at;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;

  vga_timing_gen u_def (
    .vga_clk(vga_clk), .Reset(Reset), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .sync(d_sync), .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs),
    .line_start(d_ls), .frame_count(d_fc), .anim_tick(d_at)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_DELAY(0), .ANIM_DIV(8)
  ) u_s0 (
    .vga_clk(vga_clk), .Reset(Reset), .hs(a_hs), .vs(a_vs), .blank(a_blank),
    .sync(a_sync), .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs),
    .line_start(a_ls), .frame_count(a_fc), .anim_tick(a_at)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_DELAY(3), .ANIM_DIV(1)
  ) u_s3 (
    .vga_clk(vga_clk), .Reset(Reset), .hs(b_hs), .vs(b_vs), .blank(b_blank),
    .sync(b_sync), .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs),
    .line_start(b_ls), .frame_count(b_fc), .anim_tick(b_at)
  );

  // {hs, vs, blank} of the reduced raster after n clocks from (0,0)
  function automatic logic [2:0] small_raw(input int n);
    int   h, v;
    logic hs_e, vs_e, bl_e;
    if (n < 0) return 3'b110;
    h    = n % 15;
    v    = (n / 15) % 8;
    hs_e = !(h >= 10 && h <= 12);
    vs_e = !(v >= 5 && v <= 6);
    bl_e = (h < 8) && (v < 4);
    return {hs_e, vs_e, bl_e};
  endfunction

  task automatic do_reset();
    @(negedge vga_clk);
    Reset = 1'b1;
    repeat (2) @(negedge vga_clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge vga_clk);
    checks++;
    if ({d_hs, d_vs, d_blank, d_sync} !== 4'b1100) begin
      errors++; $display("FAIL reset_sync: got %b want 1100", {d_hs, d_vs, d_blank, d_sync});
    end
    checks++;
    if (d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", d_x, d_y);
    end
    checks++;
    if ({d_fs, d_ls, d_at, d_fc} !== 11'd0) begin
      errors++; $display("FAIL reset_pulses: got %b want 0", {d_fs, d_ls, d_at, d_fc});
    end
    checks++;
    if ({b_hs, b_vs, b_blank} !== 3'b110) begin
      errors++; $display("FAIL reset_pipe3: got %b want 110", {b_hs, b_vs, b_blank});
    end
    Reset = 1'b0;
    repeat (300) @(negedge vga_clk);
    checks++;
    if (d_x !== 10'd300 || d_blank !== 1'b1) begin
      errors++; $display("FAIL run_to_300: got x=%0d blank=%b want 300 1", d_x, d_blank);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({d_hs, d_vs, d_blank} !== 3'b110 || d_x !== 10'd0 || d_y !== 10'd0) begin
      errors++; $display("FAIL async_reset: got hvb=%b x=%0d y=%0d want 110 0 0",
                         {d_hs, d_vs, d_blank}, d_x, d_y);
    end
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd0) begin
      errors++; $display("FAIL async_reset_s0: got %0d,%0d want 0,0", a_x, a_y);
    end
    @(negedge vga_clk);
    Reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge vga_clk);
      checks++;
      if (d_x !== 10'(i)) begin
        errors++; $display("FAIL count_after_reset: got %0d want %0d", d_x, i);
      end
    end
  endtask

  task automatic test_line();
    int hs_low = 0, hs_first = -1, hs_last = -1;
    int bl0 = 0, bl1 = 0, bl_first = -1;
    int ls_n = 0, ls_k0 = -1, ls_k1 = -1, xbad = 0;
    do_reset();
    for (int k = 1; k <= 1600; k++) begin
      @(negedge vga_clk);
      if (d_x !== 10'(k % 800)) xbad++;
      if (k <= 800) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_x);
          hs_last = int'(d_x);
        end
        if (d_blank) begin
          bl0++;
          if (bl_first < 0) bl_first = int'(d_x);
        end
      end else if (d_blank) begin
        bl1++;
      end
      if (d_ls) begin
        ls_n++;
        if (ls_k0 < 0) ls_k0 = k; else ls_k1 = k;
      end
    end
    checks++; if (xbad != 0)     begin errors++; $display("FAIL drawx_seq: got %0d bad want 0", xbad); end
    checks++; if (hs_low != 96)  begin errors++; $display("FAIL hs_width: got %0d want 96", hs_low); end
    checks++; if (hs_first != 657) begin errors++; $display("FAIL hs_start: got %0d want 657", hs_first); end
    checks++; if (hs_last != 752)  begin errors++; $display("FAIL hs_end: got %0d want 752", hs_last); end
    checks++; if (bl0 != 640)    begin errors++; $display("FAIL blank_line0: got %0d want 640", bl0); end
    checks++; if (bl_first != 1) begin errors++; $display("FAIL blank_start: got %0d want 1", bl_first); end
    checks++; if (bl1 != 640)    begin errors++; $display("FAIL blank_line1: got %0d want 640", bl1); end
    checks++; if (ls_n != 2)     begin errors++; $display("FAIL line_start_n: got %0d want 2", ls_n); end
    checks++; if (ls_k0 != 800)  begin errors++; $display("FAIL line_start_first: got %0d want 800", ls_k0); end
    checks++; if (ls_k1 - ls_k0 != 800) begin
      errors++; $display("FAIL line_start_period: got %0d want 800", ls_k1 - ls_k0);
    end
  endtask

  task automatic test_frame();
    int fs_k0 = -1, fs_k1 = -1, ls_between = 0, vs0 = 0, vs3 = 0, bad_fsls = 0;
    logic [19:0] vs0_first = '1, vs3_first = '1, pos119 = '0, pos120 = '1;
    do_reset();
    for (int k = 1; k <= 245; k++) begin
      @(negedge vga_clk);
      if (a_fs) begin
        if (fs_k0 < 0) fs_k0 = k; else if (fs_k1 < 0) fs_k1 = k;
      end
      if (a_ls && k > 120 && k <= 240) ls_between++;
      if ((a_fs && !a_ls) || (b_fs && !b_ls)) bad_fsls++;
      if (k <= 120 && !a_vs) begin
        vs0++;
        if (vs0 == 1) vs0_first = {a_y, a_x};
      end
      if (k <= 120 && !b_vs) begin
        vs3++;
        if (vs3 == 1) vs3_first = {b_y, b_x};
      end
      if (k == 119) pos119 = {a_y, a_x};
      if (k == 120) pos120 = {a_y, a_x};
    end
    checks++; if (fs_k0 != 120) begin errors++; $display("FAIL frame_start_first: got %0d want 120", fs_k0); end
    checks++; if (fs_k1 != 240) begin errors++; $display("FAIL frame_start_second: got %0d want 240", fs_k1); end
    checks++; if (ls_between != 8) begin errors++; $display("FAIL lines_per_frame: got %0d want 8", ls_between); end
    checks++; if (bad_fsls != 0) begin errors++; $display("FAIL frame_without_line: got %0d want 0", bad_fsls); end
    checks++; if (vs0 != 30) begin errors++; $display("FAIL vs_width_d0: got %0d want 30", vs0); end
    checks++; if (vs3 != 30) begin errors++; $display("FAIL vs_width_d3: got %0d want 30", vs3); end
    checks++; if (vs0_first !== {10'd5, 10'd0}) begin
      errors++; $display("FAIL vs_start_d0: got y=%0d x=%0d want 5 0", vs0_first[19:10], vs0_first[9:0]);
    end
    checks++; if (vs3_first !== {10'd5, 10'd3}) begin
      errors++; $display("FAIL vs_start_d3: got y=%0d x=%0d want 5 3", vs3_first[19:10], vs3_first[9:0]);
    end
    checks++; if (pos119 !== {10'd7, 10'd14} || pos120 !== 20'd0) begin
      errors++; $display("FAIL raster_wrap: got %h,%h want 01c0e,00000", pos119, pos120);
    end
  endtask

  task automatic test_sync_delay();
    int bad0 = 0, bad3 = 0, hs0 = -1, hs3 = -1, blf0 = -1, blr3 = -1;
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      @(negedge vga_clk);
      if ({a_hs, a_vs, a_blank} !== small_raw(k)) bad0++;
      if ({b_hs, b_vs, b_blank} !== small_raw(k - 3)) bad3++;
      if (!a_hs && hs0 < 0) hs0 = int'(a_x);
      if (!b_hs && hs3 < 0) hs3 = int'(b_x);
      if (!a_blank && blf0 < 0) blf0 = int'(a_x);
      if (b_blank && blr3 < 0) blr3 = int'(b_x);
    end
    checks++; if (bad0 != 0) begin errors++; $display("FAIL delay0_decode: got %0d bad want 0", bad0); end
    checks++; if (bad3 != 0) begin errors++; $display("FAIL delay3_decode: got %0d bad want 0", bad3); end
    checks++; if (hs0 != 10) begin errors++; $display("FAIL hs_edge_d0: got %0d want 10", hs0); end
    checks++; if (hs3 != 13) begin errors++; $display("FAIL hs_edge_d3: got %0d want 13", hs3); end
    checks++; if (blf0 != 8) begin errors++; $display("FAIL blank_fall_d0: got %0d want 8", blf0); end
    checks++; if (blr3 != 3) begin errors++; $display("FAIL blank_rise_d3: got %0d want 3", blr3); end
  endtask

  task automatic test_frame_count();
    int j = 0, fcbad = 0, tickbad = 0, ticks = 0, first_tick = -1, last_tick = -1;
    int fc9 = -1, fc255 = -1, fc256 = -1, s3bad = 0;
    do_reset();
    for (int k = 1; k <= 257 * 120 + 5; k++) begin
      @(negedge vga_clk);
      if (a_fs) begin
        j++;
        if (a_fc !== 8'(j)) fcbad++;
        if (a_at !== (j % 8 == 0)) tickbad++;
        if (j == 9)   fc9   = int'(a_fc);
        if (j == 255) fc255 = int'(a_fc);
        if (j == 256) fc256 = int'(a_fc);
      end else begin
        if (a_at) tickbad++;
        if (a_fc !== 8'(j)) fcbad++;
      end
      if (a_at) begin
        ticks++;
        if (first_tick < 0) first_tick = j;
        last_tick = j;
      end
      if (b_at !== b_fs) s3bad++;
    end
    checks++; if (j != 257) begin errors++; $display("FAIL frames_seen: got %0d want 257", j); end
    checks++; if (fcbad != 0) begin errors++; $display("FAIL frame_count_seq: got %0d bad want 0", fcbad); end
    checks++; if (fc9 != 9) begin errors++; $display("FAIL frame_count_9: got %0d want 9", fc9); end
    checks++; if (fc255 != 255) begin errors++; $display("FAIL frame_count_255: got %0d want 255", fc255); end
    checks++; if (fc256 != 0) begin errors++; $display("FAIL frame_count_wrap: got %0d want 0", fc256); end
    checks++; if (tickbad != 0) begin errors++; $display("FAIL anim_tick_pos: got %0d bad want 0", tickbad); end
    checks++; if (first_tick != 8) begin errors++; $display("FAIL anim_first: got %0d want 8", first_tick); end
    checks++; if (ticks != 32) begin errors++; $display("FAIL anim_count: got %0d want 32", ticks); end
    checks++; if (last_tick != 256) begin errors++; $display("FAIL anim_across_wrap: got %0d want 256", last_tick); end
    checks++; if (s3bad != 0) begin errors++; $display("FAIL anim_div1: got %0d bad want 0", s3bad); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_sync_delay();
    test_frame_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
